// File: rtl/irq_pkg.sv
// Shared sizing defaults and output-stage state encoding for the IRQ pending controller.
package irq_pkg;

  localparam int N_REQ = 4;
  localparam int POS_W = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } out_state_e;

endpackage

// File: rtl/prio_enc_lsb.sv
// Combinational lowest-index priority encoder; pos is 0 when nothing is set.
module prio_enc_lsb #(
  parameter int N_REQ = 4,
  parameter int POS_W = 2
) (
  input  logic [N_REQ-1:0] vec,
  output logic [POS_W-1:0] pos,
  output logic             any
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    pos = '0;
    any = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        pos = POS_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Edge-captures request lines into a sticky pending register and presents the
// lowest-index unmasked pending line on a valid/ready output.
//
// state   | meaning
// IDLE    | nothing presented, out_valid low
// PRESENT | out_pos holds a claimed line, waiting for out_ready
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int N_REQ = irq_pkg::N_REQ,
  parameter int POS_W = irq_pkg::POS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] mask_i,
  output logic             out_valid,
  output logic [POS_W-1:0] out_pos,
  input  logic             out_ready,
  output logic [N_REQ-1:0] ovr_o,
  input  logic [N_REQ-1:0] ovr_clr_i
);

  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] avail;
  logic [N_REQ-1:0] claim;
  logic [POS_W-1:0] enc_pos;
  logic             enc_any;
  logic             load_pos;
  out_state_e       state_q, state_d;

  assign rise  = req_i & ~req_q;
  assign avail = pending & ~mask_i;

  prio_enc_lsb #(
    .N_REQ(N_REQ),
    .POS_W(POS_W)
  ) u_enc (
    .vec(avail),
    .pos(enc_pos),
    .any(enc_any)
  );

  assign claim     = load_pos ? (N_REQ'(1) << enc_pos) : '0;
  assign out_valid = (state_q == PRESENT);

  always_comb begin
    state_d  = state_q;
    load_pos = 1'b0;
    case (state_q)
      IDLE: begin
        if (enc_any) begin
          state_d  = PRESENT;
          load_pos = 1'b1;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          if (enc_any) begin
            load_pos = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_pos <= '0;
    end else begin
      state_q <= state_d;
      if (load_pos) out_pos <= enc_pos;
    end
  end

  // A rise on the line being claimed this cycle re-arms it rather than overrunning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      pending <= '0;
      ovr_o   <= '0;
    end else begin
      req_q   <= req_i;
      pending <= (pending & ~claim) | rise;
      ovr_o   <= (ovr_o & ~ovr_clr_i) | (rise & pending & ~claim);
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Scoreboard bench: expected positions are queued as stimulus is applied and
// popped by a monitor on every accepted handshake.
module tb_irq_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_i;
  logic [3:0] mask_i;
  logic       out_valid;
  logic [1:0] out_pos;
  logic       out_ready;
  logic [3:0] ovr_o;
  logic [3:0] ovr_clr_i;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];

  irq_pending_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_i(req_i),
    .mask_i(mask_i),
    .out_valid(out_valid),
    .out_pos(out_pos),
    .out_ready(out_ready),
    .ovr_o(ovr_o),
    .ovr_clr_i(ovr_clr_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake completes on the next rising edge; inputs are stable by the falling edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", int'(out_pos), -1);
      end else begin
        check("sb_pos", int'(out_pos), exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; req_i = 4'b0100; mask_i = '0; out_ready = 1'b0; ovr_clr_i = '0;

    // 1: line held high through reset counts as one edge
    tick(); tick();
    check("rst_valid", int'(out_valid), 0);
    check("rst_ovr", int'(ovr_o), 0);
    check("rst_pending", int'(dut.pending), 0);
    rst_n = 1'b1;
    tick();
    check("t1_valid_e1", int'(out_valid), 0);
    check("t1_pend_e1", int'(dut.pending), 4'b0100);
    tick();
    check("t1_valid_e2", int'(out_valid), 1);
    check("t1_pos_e2", int'(out_pos), 2);
    exp_q.push_back(2);
    out_ready = 1'b1;
    tick();
    check("t1_idle", int'(out_valid), 0);
    req_i = '0;
    tick();

    // 2: two lines at once, back-to-back presentation
    req_i = 4'b1010;
    exp_q.push_back(1); exp_q.push_back(3);
    tick();
    check("t2_valid_a", int'(out_valid), 0);
    tick();
    check("t2_pos1", int'(out_pos), 1);
    check("t2_valid1", int'(out_valid), 1);
    tick();
    check("t2_pos3", int'(out_pos), 3);
    check("t2_valid3", int'(out_valid), 1);
    tick();
    check("t2_idle", int'(out_valid), 0);
    req_i = '0;
    tick();

    // 3: stalled consumer while another line rises
    out_ready = 1'b0;
    req_i = 4'b0001;
    tick(); tick();
    check("t3_pos0", int'(out_pos), 0);
    req_i = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_valid", int'(out_valid), 1);
      check("t3_hold_pos", int'(out_pos), 0);
    end
    check("t3_pending", int'(dut.pending), 4'b0100);
    exp_q.push_back(0); exp_q.push_back(2);
    out_ready = 1'b1;
    tick();
    check("t3_pos2", int'(out_pos), 2);
    tick();
    check("t3_idle", int'(out_valid), 0);
    req_i = '0;
    tick();

    // 4: masked line stays pending until unmasked
    mask_i = 4'b0001;
    req_i = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_masked_valid", int'(out_valid), 0);
    end
    check("t4_pend0", int'(dut.pending[0]), 1);
    mask_i = '0;
    exp_q.push_back(0);
    tick();
    check("t4_valid", int'(out_valid), 1);
    check("t4_pos", int'(out_pos), 0);
    tick();
    check("t4_idle", int'(out_valid), 0);
    req_i = '0;
    tick();

    // 5: overrun on a masked line, clear, set-wins-over-clear
    mask_i = 4'b0010;
    req_i = 4'b0010; tick();
    req_i = 4'b0000; tick();
    check("t5_ovr_pre", int'(ovr_o), 0);
    req_i = 4'b0010; tick();
    check("t5_ovr_set", int'(ovr_o), 4'b0010);
    req_i = 4'b0000;
    ovr_clr_i = 4'b0010; tick();
    check("t5_ovr_clr", int'(ovr_o), 0);
    ovr_clr_i = 4'b0010; req_i = 4'b0010; tick();
    check("t5_set_wins", int'(ovr_o), 4'b0010);
    req_i = 4'b0000; tick();
    check("t5_ovr_clr2", int'(ovr_o), 0);
    ovr_clr_i = '0;
    check("t5_masked_valid", int'(out_valid), 0);
    exp_q.push_back(1);
    mask_i = '0;
    tick();
    check("t5_pos1", int'(out_pos), 1);
    tick();
    check("t5_idle", int'(out_valid), 0);
    tick(); tick();
    check("t5_single", int'(out_valid), 0);

    // 6: reset mid-handshake drops everything immediately
    out_ready = 1'b0;
    req_i = 4'b1101;
    tick(); tick();
    check("t6_valid_pre", int'(out_valid), 1);
    check("t6_pend_pre", int'(dut.pending), 4'b1100);
    rst_n = 1'b0;
    #1;
    check("t6_valid_rst", int'(out_valid), 0);
    check("t6_pend_rst", int'(dut.pending), 0);
    check("t6_ovr_rst", int'(ovr_o), 0);
    req_i = '0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_no_out", int'(out_valid), 0);
    end

    check("sb_leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
